// File: rtl/csel_adder_pkg.sv
// csel_adder_pkg: mode encodings and stage-count helper shared by the carry-select adder files
package csel_adder_pkg;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    function automatic int csel_nseg(input int width, input int seg);
        return width / seg;
    endfunction
endpackage

// File: rtl/pipelined_csel_adder_if.sv
// pipelined_csel_adder_if: operand/result handshake bundle
//   in_valid/in_ready/a/b/cin/mode : operand issue channel
//   out_valid/out_ready/sum/cout/ovf : result channel
//   master = operand issuer and result consumer, slave = the adder
interface pipelined_csel_adder_if #(
    parameter int WIDTH = 32
);
    logic in_valid, in_ready, cin, mode;
    logic out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csel_segment.sv
// csel_segment: combinational SEG-bit carry-select cell
//   a_seg, b_seg : operand segments (b already mode-adjusted)
//   sel_cin      : carry into the segment, selects the carry-0 or carry-1 result
//   seg_sum      : selected segment sum
//   seg_cout     : carry out of the segment
//   msb_cin      : carry into the segment MSB, used for signed overflow
module csel_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           sel_cin,
    output logic [SEG-1:0] seg_sum,
    output logic           seg_cout,
    output logic           msb_cin
);
    logic [SEG:0] c0, c1;
    logic [SEG-1:0] p;
    assign p = a_seg ^ b_seg;
    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;
    for (genvar k = 0; k < SEG; k++) begin : g_bit
        assign c0[k+1] = (a_seg[k] & b_seg[k]) | (c0[k] & p[k]);
        assign c1[k+1] = (a_seg[k] & b_seg[k]) | (c1[k] & p[k]);
    end
    assign seg_sum  = sel_cin ? p ^ c1[SEG-1:0] : p ^ c0[SEG-1:0];
    assign seg_cout = sel_cin ? c1[SEG] : c0[SEG];
    assign msb_cin  = sel_cin ? c1[SEG-1] : c0[SEG-1];
endmodule

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: pipelined carry-select adder/subtractor, one SEG-bit segment resolved per stage
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_csel_adder_if (operands in, sum/cout/ovf out, valid/ready both ways)
module pipelined_csel_adder
    import csel_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic clk,
    input logic rst_n,
    pipelined_csel_adder_if.slave bus
);
    localparam int NSEG = csel_nseg(WIDTH, SEG);
    if (SEG < 1 || WIDTH < SEG || WIDTH % SEG != 0) begin : g_bad_params
        $error("pipelined_csel_adder: WIDTH must be a positive multiple of SEG");
    end
    logic adv, out_v, cin_eff;
    logic [WIDTH-1:0] b_eff;
    // the whole pipe moves together; it only freezes when a finished result is refused
    assign adv = !out_v || bus.out_ready;
    assign bus.in_ready = adv;
    assign b_eff = bus.mode == MODE_SUB ? ~bus.b : bus.b;
    assign cin_eff = bus.mode == MODE_SUB ? ~bus.cin : bus.cin;
    for (genvar i = 0; i < NSEG; i++) begin : g_stage
        localparam int IW = WIDTH - i * SEG;
        localparam int SW = (i + 1) * SEG;
        logic v, v_d, ld, c, sc, co, mc;
        logic [IW-1:0] a_in, b_in;
        logic [SW-1:0] s_q, s_d;
        logic [SEG-1:0] ss;
        if (i == 0) begin : g_head
            // operand registers only load on a real transfer so idle inputs never enter the pipe
            assign v_d  = bus.in_valid;
            assign ld   = bus.in_valid;
            assign a_in = bus.a;
            assign b_in = b_eff;
            assign sc   = cin_eff;
            assign s_d  = ss;
        end else begin : g_body
            assign v_d  = g_stage[i-1].v;
            assign ld   = 1'b1;
            assign a_in = g_stage[i-1].g_fwd.a_q;
            assign b_in = g_stage[i-1].g_fwd.b_q;
            assign sc   = g_stage[i-1].c;
            assign s_d  = {ss, g_stage[i-1].s_q};
        end
        csel_segment #(.SEG(SEG)) u_seg (
            .a_seg   (a_in[SEG-1:0]),
            .b_seg   (b_in[SEG-1:0]),
            .sel_cin (sc),
            .seg_sum (ss),
            .seg_cout(co),
            .msb_cin (mc)
        );
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v   <= 1'b0;
                c   <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v <= v_d;
                if (ld) begin
                    c   <= co;
                    s_q <= s_d;
                end
            end
        end
        // unresolved upper operand segments travel down the pipe, shrinking by one segment per stage
        if (IW > SEG) begin : g_fwd
            logic [IW-SEG-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && ld) begin
                    a_q <= a_in[IW-1:SEG];
                    b_q <= b_in[IW-1:SEG];
                end
            end
        end
        if (i == NSEG - 1) begin : g_last
            logic o;
            // signed overflow: carry into the MSB differs from carry out of it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) o <= 1'b0;
                else if (adv && ld) o <= mc ^ co;
            end
        end else begin : g_mid
            logic unused_mc;
            assign unused_mc = mc;
        end
    end
    assign out_v         = g_stage[NSEG-1].v;
    assign bus.out_valid = out_v;
    assign bus.sum       = g_stage[NSEG-1].s_q;
    assign bus.cout      = g_stage[NSEG-1].c;
    assign bus.ovf       = g_stage[NSEG-1].g_last.o;
endmodule
